// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer: streams num_pixels bytes from a source RAM through
// pixel_operator into a destination RAM, with latency-aligned write strobes.
module pixel_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17,
    parameter int OP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_pixels,
    input  logic [1:0]        cfg_select,
    input  logic [DATA_W-1:0] cfg_threshold,
    input  logic [DATA_W-1:0] cfg_value,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] op_inbyte,
    output logic [1:0]        op_select,
    output logic [DATA_W-1:0] op_threshold,
    output logic [DATA_W-1:0] op_value,
    input  logic [DATA_W-1:0] op_outbyte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] px_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] num_q;
    logic [OP_LAT:0]   vpipe;
    logic [ADDR_W-1:0] apipe [0:OP_LAT];
    logic              last_rd;
    logic              kill;

    assign op_inbyte = rd_data;
    assign wr_data   = op_outbyte;
    assign wr_en     = vpipe[OP_LAT];
    assign wr_addr   = apipe[OP_LAT];
    assign last_rd   = rd_en && (rd_addr == num_q - ONE);
    assign kill      = abort && (state != IDLE);

    // Stage k holds the read issued k+1 cycles ago; the top stage lines up with op_outbyte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
        end else if (kill) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[OP_LAT-1:0], rd_en};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= OP_LAT; k++) apipe[k] <= '0;
        end else begin
            apipe[0] <= rd_addr;
            for (int k = 1; k <= OP_LAT; k++) apipe[k] <= apipe[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            num_q        <= '0;
            op_select    <= '0;
            op_threshold <= '0;
            op_value     <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            px_count     <= '0;
        end else begin
            if (wr_en) px_count <= px_count + ONE;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_q        <= num_pixels;
                        op_select    <= cfg_select;
                        op_threshold <= cfg_threshold;
                        op_value     <= cfg_value;
                        rd_addr      <= '0;
                        px_count     <= '0;
                        if (num_pixels == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        rd_en <= 1'b0;
                        busy  <= 1'b0;
                    end else if (last_rd) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + ONE;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vpipe[OP_LAT-1:0] == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
